// File: rtl/data_ram.sv
// data_ram: synchronous single-port data memory for the MEM stage.
// Accepts one request at a time, holds it for LATENCY cycles, then commits
// the write (with byte-lane strobes) or returns the read word alongside a
// one-cycle data_ready_o pulse.
//
// Ports:
//   clk_i            clock, all state changes on the rising edge
//   rst_i            synchronous active-high reset (memory contents kept)
//   ram_ce_i         request valid (sampled only while idle)
//   ram_w_request_i  1 = write, 0 = read
//   ram_addr_i       byte address; word index is addr[DEPTH_LOG2+1:2]
//   ram_sel_i        byte-lane write strobes (ignored on reads)
//   ram_data_i       lane-aligned write data
//   ram_data_o       read data, updated only by a read commit
//   data_ready_o     one-cycle completion pulse
//   busy_o           request in flight
module data_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ce_i,
  input  logic        ram_w_request_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        data_ready_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            count;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;

  logic [31:0]           mem [0:DEPTH-1];

  logic                  commit;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  c_we;
  logic [3:0]            c_sel;
  logic [31:0]           c_wdata;

  logic                  unused_addr;
  assign unused_addr = ^{ram_addr_i[31:DEPTH_LOG2+2], ram_addr_i[1:0]};

  // With LATENCY=1 the commit happens on the acceptance edge itself, before
  // the capture registers hold the request, so the operands come straight
  // from the inputs in that one case.
  always_comb begin
    commit  = 1'b0;
    c_idx   = idx_q;
    c_we    = we_q;
    c_sel   = sel_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      if (LATENCY == 1 && ram_ce_i) begin
        commit  = 1'b1;
        c_idx   = ram_addr_i[DEPTH_LOG2+1:2];
        c_we    = ram_w_request_i;
        c_sel   = ram_sel_i;
        c_wdata = ram_data_i;
      end
    end else if (state == WAIT) begin
      commit = (count == 4'd1);
    end
  end

  // Request sequencing and read data return. The counter is loaded with
  // LATENCY-1 so that WAIT lasts LATENCY-1 cycles and RESP lands LATENCY
  // cycles after acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= 4'd0;
      ram_data_o <= 32'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_ce_i) begin
            idx_q   <= ram_addr_i[DEPTH_LOG2+1:2];
            we_q    <= ram_w_request_i;
            sel_q   <= ram_sel_i;
            wdata_q <= ram_data_i;
            count   <= 4'(LATENCY - 1);
            state   <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (commit && !c_we) begin
        ram_data_o <= mem[c_idx];
      end
    end
  end

  // Memory array has no reset; a reset on the commit edge suppresses the
  // write so an aborted request never modifies memory.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && c_we) begin
      for (int n = 0; n < 4; n++) begin
        if (c_sel[n]) begin
          mem[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
        end
      end
    end
  end

  assign busy_o       = (state != IDLE);
  assign data_ready_o = (state == RESP);

endmodule
